// File: rtl/fft_frame_scheduler.sv
// Round-robin frame scheduler: shares one FFT core between two sample sources,
// loads whole frames into it and drains the results to one tagged output port.
module fft_frame_scheduler #(
  parameter int SIZE_BUFFER   = 8,
  parameter int DATA_FFT_SIZE = 16,
  parameter int SIZE_DATA_OUT = DATA_FFT_SIZE + SIZE_BUFFER - 2,
  parameter int TIMEOUT       = 8191
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  output logic                     gnt0,
  output logic                     gnt1,
  input  logic [DATA_FFT_SIZE-1:0] src0_i,
  input  logic [DATA_FFT_SIZE-1:0] src0_q,
  input  logic [DATA_FFT_SIZE-1:0] src1_i,
  input  logic [DATA_FFT_SIZE-1:0] src1_q,
  output logic                     fft_valid,
  output logic [DATA_FFT_SIZE-1:0] fft_data_i,
  output logic [DATA_FFT_SIZE-1:0] fft_data_q,
  input  logic                     fft_wait_data,
  input  logic                     fft_complete,
  input  logic [SIZE_DATA_OUT-1:0] fft_out_i,
  input  logic [SIZE_DATA_OUT-1:0] fft_out_q,
  output logic                     fft_ready_recive,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_DATA_OUT-1:0] out_i,
  output logic [SIZE_DATA_OUT-1:0] out_q,
  output logic                     out_src,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int unsigned NFFT = 2 ** SIZE_BUFFER;
  localparam int unsigned CW   = SIZE_BUFFER + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_PROC  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            ld_cnt_q, ld_cnt_d;
  logic [TW-1:0]            to_cnt_q, to_cnt_d;
  logic [CW-1:0]            out_cnt_q, out_cnt_d;
  logic                     last_src_q, last_src_d;
  logic                     src_q, src_d;
  logic                     gnt0_q, gnt0_d;
  logic                     gnt1_q, gnt1_d;
  logic                     fft_valid_q, fft_valid_d;
  logic [DATA_FFT_SIZE-1:0] fft_di_q, fft_di_d;
  logic [DATA_FFT_SIZE-1:0] fft_dq_q, fft_dq_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic in_drain;
  logic xfer;
  logic win;

  // Result path is a straight pass-through of the core, gated to DRAIN.
  assign in_drain         = (state_q == ST_DRAIN);
  assign fft_ready_recive = in_drain & out_ready;
  assign out_valid        = in_drain & fft_complete;
  assign out_i            = in_drain ? fft_out_i : '0;
  assign out_q            = in_drain ? fft_out_q : '0;
  assign out_last         = out_valid & (out_cnt_q == CW'(NFFT - 1));
  assign xfer             = out_valid & out_ready;

  // Tie goes to the source that did not win last; a lone requester always wins.
  assign win = (req0 && req1) ? ~last_src_q : req1;

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    to_cnt_d    = to_cnt_q;
    out_cnt_d   = out_cnt_q;
    last_src_d  = last_src_q;
    src_d       = src_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (fft_wait_data && (req0 || req1)) begin
          state_d    = ST_LOAD;
          ld_cnt_d   = '0;
          gnt0_d     = ~win;
          gnt1_d     = win;
          src_d      = win;
          last_src_d = win;
        end
      end
      ST_LOAD: begin
        if (ld_cnt_q == CW'(NFFT - 1)) begin
          state_d  = ST_PROC;
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          ld_cnt_d = '0;
          to_cnt_d = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + CW'(1);
        end
      end
      ST_PROC: begin
        if (fft_complete) begin
          state_d   = ST_DRAIN;
          out_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          if (out_cnt_q == CW'(NFFT - 1)) begin
            state_d   = ST_IDLE;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Core input is the granted sample, one cycle behind the grant.
    fft_valid_d = gnt0_q | gnt1_q;
    fft_di_d    = gnt0_q ? src0_i : (gnt1_q ? src1_i : '0);
    fft_dq_d    = gnt0_q ? src0_q : (gnt1_q ? src1_q : '0);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ld_cnt_q    <= '0;
      to_cnt_q    <= '0;
      out_cnt_q   <= '0;
      last_src_q  <= 1'b1;
      src_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      fft_valid_q <= 1'b0;
      fft_di_q    <= '0;
      fft_dq_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      to_cnt_q    <= to_cnt_d;
      out_cnt_q   <= out_cnt_d;
      last_src_q  <= last_src_d;
      src_q       <= src_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      fft_valid_q <= fft_valid_d;
      fft_di_q    <= fft_di_d;
      fft_dq_q    <= fft_dq_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign fft_valid   = fft_valid_q;
  assign fft_data_i  = fft_di_q;
  assign fft_data_q  = fft_dq_q;
  assign out_src     = src_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: behavioural FFT core, two sources and a
// frame scoreboard mapping every sent sample to its expected tagged result.
module tb_fft_frame_scheduler;

  localparam int SB   = 8;
  localparam int DW   = 16;
  localparam int SDO  = DW + SB - 2;
  localparam int TW   = SDO - DW;
  localparam int NFFT = 2 ** SB;
  localparam int TMO  = 50;

  typedef struct packed {
    logic           src;
    logic           last;
    logic [SDO-1:0] i;
    logic [SDO-1:0] q;
  } olog_t;

  typedef struct packed {
    logic          src;
    logic [2*DW-1:0] s;
  } sent_t;

  logic           clk, reset, req0, req1, gnt0, gnt1;
  logic [DW-1:0]  src0_i, src0_q, src1_i, src1_q, fft_data_i, fft_data_q;
  logic           fft_valid, fft_wait_data, fft_complete, fft_ready_recive;
  logic [SDO-1:0] fft_out_i, fft_out_q, out_i, out_q;
  logic           out_valid, out_ready, out_src, out_last, busy, err_timeout;

  fft_frame_scheduler #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(DW), .SIZE_DATA_OUT(SDO), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .src0_i(src0_i), .src0_q(src0_q), .src1_i(src1_i), .src1_q(src1_q),
    .fft_valid(fft_valid), .fft_data_i(fft_data_i), .fft_data_q(fft_data_q),
    .fft_wait_data(fft_wait_data), .fft_complete(fft_complete),
    .fft_out_i(fft_out_i), .fft_out_q(fft_out_q), .fft_ready_recive(fft_ready_recive),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .out_src(out_src), .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [2*DW-1:0] frame0 [0:NFFT-1];
  logic [2*DW-1:0] frame1 [0:NFFT-1];
  logic core_en, bp, bubbles;

  // Observations gathered once per cycle just before the rising edge.
  sent_t           sent[$];
  olog_t           out_log[$], ref_log[$];
  logic            order[$];
  logic [2*DW-1:0] in_frame[$], core_frame[$];
  int g0_cyc, g1_cyc, both, fv_cyc, fv_err, rr_err, stall_cyc;
  int core_st, core_lat, oidx;

  // Behavioural core transform: distinct, index-dependent result per sample.
  function automatic logic [SDO-1:0] exp_i(input logic [2*DW-1:0] s, input int k);
    return {s[2*DW-1:DW], TW'(k)};
  endfunction

  function automatic logic [SDO-1:0] exp_q(input logic [2*DW-1:0] s, input int k);
    return {s[DW-1:0] ^ DW'(16'hA5A5), TW'(~k)};
  endfunction

  function automatic olog_t mk_exp(input sent_t e, input int j);
    olog_t r;
    int k;
    k      = j % NFFT;
    r.src  = e.src;
    r.last = (k == NFFT - 1);
    r.i    = exp_i(e.s, k);
    r.q    = exp_q(e.s, k);
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Input driver: core outputs, source samples and downstream ready.
  initial begin
    int g0idx, g1idx, pidx;
    g0idx = 0; g1idx = 0; pidx = 0;
    fft_complete = 1'b0; fft_out_i = '0; fft_out_q = '0;
    src0_i = '0; src0_q = '0; src1_i = '0; src1_q = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (core_st == 2 && oidx < NFFT) begin
        fft_complete = !bubbles || ($urandom_range(0, 3) != 0);
        fft_out_i    = exp_i(core_frame[oidx], oidx);
        fft_out_q    = exp_q(core_frame[oidx], oidx);
      end else begin
        fft_complete = 1'b0;
        fft_out_i    = SDO'($urandom);
        fft_out_q    = SDO'($urandom);
      end
      if (gnt0) begin {src0_i, src0_q} = frame0[g0idx % NFFT]; g0idx++; end
      else begin g0idx = 0; {src0_i, src0_q} = $urandom; end
      if (gnt1) begin {src1_i, src1_q} = frame1[g1idx % NFFT]; g1idx++; end
      else begin g1idx = 0; {src1_i, src1_q} = $urandom; end
      out_ready = bp ? ((pidx % 4 == 0) || (pidx % 4 == 3)) : 1'b1;
      pidx++;
    end
  end

  // Monitor and core model, sampled 1 time unit before each rising edge.
  initial begin
    logic prev_g, pg0, pg1;
    logic [2*DW-1:0] prev_d;
    olog_t e;
    prev_g = 1'b0; pg0 = 1'b0; pg1 = 1'b0; prev_d = '0;
    core_st = 0; core_lat = 0; oidx = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        prev_g = 1'b0; pg0 = 1'b0; pg1 = 1'b0; core_st = 0;
        in_frame.delete();
      end else begin
        if (fft_valid !== prev_g) fv_err++;
        else if (fft_valid && ({fft_data_i, fft_data_q} !== prev_d)) fv_err++;
        if (fft_valid) begin fv_cyc++; in_frame.push_back({fft_data_i, fft_data_q}); end
        if (gnt0 && gnt1) both++;
        if (gnt0) begin g0_cyc++; sent.push_back({1'b0, src0_i, src0_q}); end
        else if (gnt1) sent.push_back({1'b1, src1_i, src1_q});
        if (gnt1) g1_cyc++;
        if (gnt0 && !pg0) order.push_back(1'b0);
        if (gnt1 && !pg1) order.push_back(1'b1);
        prev_g = gnt0 | gnt1;
        prev_d = gnt0 ? {src0_i, src0_q} : {src1_i, src1_q};
        pg0 = gnt0; pg1 = gnt1;
        if ((fft_ready_recive && !out_ready) || (!busy && fft_ready_recive) ||
            (out_valid && (fft_ready_recive !== out_ready))) rr_err++;
        if (out_valid && !out_ready) stall_cyc++;
        if (out_valid && out_ready) begin
          e.src = out_src; e.last = out_last; e.i = out_i; e.q = out_q;
          out_log.push_back(e);
        end
        case (core_st)
          0: if (in_frame.size() == NFFT) begin
               if (core_en) begin
                 core_frame = in_frame;
                 core_st    = 1;
                 core_lat   = $urandom_range(1, 8);
               end
               in_frame.delete();
             end
          1: if (core_lat == 0) begin core_st = 2; oidx = 0; end
             else core_lat--;
          default: if (fft_complete && fft_ready_recive) begin
               oidx++;
               if (oidx == NFFT) core_st = 0;
             end
        endcase
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    sent.delete(); out_log.delete(); order.delete();
    g0_cyc = 0; g1_cyc = 0; both = 0; fv_cyc = 0; fv_err = 0; rr_err = 0; stall_cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; fft_wait_data = 1'b1;
    bp = 1'b0; bubbles = 1'b0; core_en = 1'b1;
    repeat (2) step();
    clear_logs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; fft_wait_data = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({gnt0, gnt1, fft_valid, out_valid, out_last, out_src, busy, err_timeout, fft_ready_recive} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {gnt0, gnt1, fft_valid, out_valid, out_last, out_src, busy, err_timeout, fft_ready_recive});
    end
    n_cmp++;
    if ({fft_data_i, fft_data_q} !== '0) begin
      n_fail++; $display("FAIL reset_fft_data: got %h required 0", {fft_data_i, fft_data_q});
    end
    n_cmp++;
    if ({out_i, out_q} !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %h required 0", {out_i, out_q});
    end
    req0 = 1'b0; req1 = 1'b0;
    clear_logs();
    reset = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({busy, gnt0, gnt1} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 000", {busy, gnt0, gnt1});
    end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1;
    for (int c = 0; c < 20 && !gnt0; c++) step();
    req0 = 1'b0;
    for (int c = 0; c < 3000 && !(out_log.size() >= NFFT && !busy); c++) step();
    n_cmp++;
    if (g0_cyc !== NFFT || g1_cyc !== 0) begin
      n_fail++; $display("FAIL single_gnt_cycles: got %0d/%0d required %0d/0", g0_cyc, g1_cyc, NFFT);
    end
    n_cmp++;
    if (fv_cyc !== NFFT || fv_err !== 0) begin
      n_fail++; $display("FAIL single_fft_valid: got %0d cycles %0d errs required %0d cycles 0 errs", fv_cyc, fv_err, NFFT);
    end
    n_cmp++;
    if (out_log.size() !== NFFT || sent.size() !== NFFT) begin
      n_fail++; $display("FAIL single_count: got %0d out %0d sent required %0d", out_log.size(), sent.size(), NFFT);
    end
    for (int j = 0; j < out_log.size() && j < sent.size(); j++) begin
      n_cmp++;
      if (out_log[j] !== mk_exp(sent[j], j)) begin
        n_fail++; $display("FAIL single_out[%0d]: got %h required %h", j, out_log[j], mk_exp(sent[j], j));
      end
    end
    ref_log = out_log;
  endtask

  task automatic test_backpressure();
    do_reset();
    bp = 1'b1;
    req0 = 1'b1;
    for (int c = 0; c < 20 && !gnt0; c++) step();
    req0 = 1'b0;
    for (int c = 0; c < 3000 && !(out_log.size() >= NFFT && !busy); c++) step();
    n_cmp++;
    if (out_log.size() !== NFFT) begin
      n_fail++; $display("FAIL bp_count: got %0d required %0d", out_log.size(), NFFT);
    end
    n_cmp++;
    if (rr_err !== 0) begin
      n_fail++; $display("FAIL bp_ready_mirror: got %0d bad cycles required 0", rr_err);
    end
    n_cmp++;
    if (stall_cyc == 0) begin
      n_fail++; $display("FAIL bp_stalls: got %0d stalled cycles required nonzero", stall_cyc);
    end
    for (int j = 0; j < out_log.size() && j < ref_log.size() && j < sent.size(); j++) begin
      n_cmp++;
      if (out_log[j] !== ref_log[j] || out_log[j] !== mk_exp(sent[j], j)) begin
        n_fail++; $display("FAIL bp_out[%0d]: got %h required %h", j, out_log[j], mk_exp(sent[j], j));
      end
    end
    bp = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    bubbles = 1'b1;
    for (int k = 0; k < NFFT; k++) begin frame0[k] = $urandom; frame1[k] = $urandom; end
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 8000 && !(order.size() >= 4 && out_log.size() >= 4 * NFFT && !busy); c++) begin
      step();
      if (order.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    n_cmp++;
    if (order.size() !== 4) begin
      n_fail++; $display("FAIL tie_grants: got %0d grants required 4", order.size());
    end
    for (int j = 0; j < order.size() && j < 4; j++) begin
      n_cmp++;
      if (order[j] !== 1'(j % 2)) begin
        n_fail++; $display("FAIL tie_order[%0d]: got %0d required %0d", j, order[j], j % 2);
      end
    end
    n_cmp++;
    if (both !== 0 || fv_err !== 0) begin
      n_fail++; $display("FAIL tie_exclusive: got %0d overlap %0d valid errs required 0", both, fv_err);
    end
    n_cmp++;
    if (out_log.size() !== 4 * NFFT || sent.size() !== 4 * NFFT) begin
      n_fail++; $display("FAIL tie_count: got %0d out %0d sent required %0d", out_log.size(), sent.size(), 4 * NFFT);
    end
    for (int j = 0; j < out_log.size() && j < sent.size(); j++) begin
      n_cmp++;
      if (out_log[j] !== mk_exp(sent[j], j)) begin
        n_fail++; $display("FAIL tie_out[%0d]: got %h required %h", j, out_log[j], mk_exp(sent[j], j));
      end
    end
    bubbles = 1'b0;
  endtask

  task automatic test_core_not_ready();
    int bad;
    do_reset();
    bad = 0;
    fft_wait_data = 1'b0;
    req1 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (gnt0 || gnt1 || busy) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL nr_hold: got %0d cycles with grant or busy required 0", bad);
    end
    fft_wait_data = 1'b1;
    step();
    n_cmp++;
    if ({gnt1, gnt0, busy} !== 3'b101) begin
      n_fail++; $display("FAIL nr_grant_latency: got gnt1,gnt0,busy=%b required 101", {gnt1, gnt0, busy});
    end
    req1 = 1'b0;
    for (int c = 0; c < 3000 && !(out_log.size() >= NFFT && !busy); c++) step();
    n_cmp++;
    if (out_log.size() !== NFFT || g1_cyc !== NFFT) begin
      n_fail++; $display("FAIL nr_count: got %0d out %0d gnt1 required %0d", out_log.size(), g1_cyc, NFFT);
    end
    for (int j = 0; j < out_log.size() && j < sent.size(); j++) begin
      n_cmp++;
      if (out_log[j] !== mk_exp(sent[j], j)) begin
        n_fail++; $display("FAIL nr_out[%0d]: got %h required %h", j, out_log[j], mk_exp(sent[j], j));
      end
    end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    core_en = 1'b0;
    req0 = 1'b1;
    for (int c = 0; c < 20 && !gnt0; c++) step();
    req0 = 1'b0;
    for (int c = 0; c < 400 && gnt0; c++) step();
    k = 0;
    while (!err_timeout && k < 200) begin step(); k++; end
    n_cmp++;
    if (k !== TMO) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles required %0d", k, TMO);
    end
    n_cmp++;
    if ({err_timeout, busy} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_state: got err,busy=%b required 10", {err_timeout, busy});
    end
    repeat (3) step();
    core_en = 1'b1;
    clear_logs();
    req0 = 1'b1;
    for (int c = 0; c < 20 && !gnt0; c++) step();
    req0 = 1'b0;
    for (int c = 0; c < 3000 && !(out_log.size() >= NFFT && !busy); c++) step();
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b required 1", err_timeout);
    end
    n_cmp++;
    if (out_log.size() !== NFFT) begin
      n_fail++; $display("FAIL timeout_next_frame: got %0d required %0d", out_log.size(), NFFT);
    end
    for (int j = 0; j < out_log.size() && j < sent.size(); j++) begin
      n_cmp++;
      if (out_log[j] !== mk_exp(sent[j], j)) begin
        n_fail++; $display("FAIL timeout_out[%0d]: got %h required %h", j, out_log[j], mk_exp(sent[j], j));
      end
    end
    do_reset();
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %b required 0", err_timeout);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    req0 = 1'b1;
    for (int c = 0; c < 200 && g0_cyc < 100; c++) step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({gnt0, fft_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL midload_async: got gnt0,valid,busy=%b required 000", {gnt0, fft_valid, busy});
    end
    repeat (3) step();
    clear_logs();
    reset = 1'b1;
    for (int c = 0; c < 20 && !gnt0; c++) step();
    req0 = 1'b0;
    for (int c = 0; c < 3000 && !(out_log.size() >= NFFT && !busy); c++) step();
    n_cmp++;
    if (g0_cyc !== NFFT || fv_cyc !== NFFT || fv_err !== 0) begin
      n_fail++; $display("FAIL midload_regrant: got %0d gnt %0d valid %0d errs required %0d/%0d/0", g0_cyc, fv_cyc, fv_err, NFFT, NFFT);
    end
    n_cmp++;
    if (out_log.size() !== NFFT) begin
      n_fail++; $display("FAIL midload_count: got %0d required %0d", out_log.size(), NFFT);
    end
    for (int j = 0; j < out_log.size() && j < sent.size(); j++) begin
      n_cmp++;
      if (out_log[j] !== mk_exp(sent[j], j)) begin
        n_fail++; $display("FAIL midload_out[%0d]: got %h required %h", j, out_log[j], mk_exp(sent[j], j));
      end
    end
  endtask

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; fft_wait_data = 1'b1;
    core_en = 1'b1; bp = 1'b0; bubbles = 1'b0;
    for (int k = 0; k < NFFT; k++) begin
      frame0[k] = {DW'(k), DW'($urandom)};
      frame1[k] = $urandom;
    end
    test_reset();
    test_single();
    test_backpressure();
    test_core_not_ready();
    test_tie();
    test_timeout();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Two-requester frame scheduler that shares one `myFFT` core between two sample sources. It arbitrates whole NFFT-sample frames round-robin and streams the granted source into the core. It then waits for the core result and drains the NFFT output samples to a single downstream port, tagged with the source and a last marker. It sits between the OFDM symbol builders/receivers and the FFT core.

## Interface
- `SIZE_BUFFER`, 8, log2 of frame length; NFFT = 2**SIZE_BUFFER.
- `DATA_FFT_SIZE`, 16, input sample width per I/Q rail.
- `SIZE_DATA_OUT`, DATA_FFT_SIZE+SIZE_BUFFER-2, core output width per rail.
- `TIMEOUT`, 8191, maximum cycles in PROC before the block aborts the frame.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `req0`, `req1` in 1: frame request from source 0 and source 1 (level).
- `gnt0`, `gnt1` out 1: grant; the source must drive one sample per cycle while its grant is high.
- `src0_i`, `src0_q`, `src1_i`, `src1_q` in DATA_FFT_SIZE: source samples.
- `fft_valid` out 1: to core `valid`.
- `fft_data_i`, `fft_data_q` out DATA_FFT_SIZE: to core `data_in_i/q`.
- `fft_wait_data` in 1: core `flag_wayt_data`; 1 = core can accept a frame.
- `fft_complete` in 1: core `complete`; 1 = output sample valid.
- `fft_out_i`, `fft_out_q` in SIZE_DATA_OUT: core `data_out_i/q`.
- `fft_ready_recive` out 1: to core `flag_ready_recive`.
- `out_valid` out 1, `out_ready` in 1: downstream handshake; a transfer occurs when both are 1.
- `out_i`, `out_q` out SIZE_DATA_OUT: result samples.
- `out_src` out 1: source index of the current frame.
- `out_last` out 1: high on the NFFT-th output sample.
- `busy` out 1: state is not IDLE.
- `err_timeout` out 1: sticky; set on a PROC timeout; cleared only by reset.

## Operation
- **States:** IDLE, LOAD, PROC, DRAIN.
- **IDLE**
  - When `fft_wait_data`=1 and any `req` is high, the block grants and moves to LOAD.
  - Round-robin arbitration: the requester other than `last_src` wins on a tie. A lone requester always wins.
  - `last_src` resets to 1, so source 0 wins the first tie.
- **LOAD**
  - The winning `gnt` is high for exactly NFFT cycles. A 9-bit-wide (SIZE_BUFFER+1) load counter runs 0..NFFT-1.
  - `fft_valid`, `fft_data_i/q` are registered copies of the granted grant and muxed sample, delayed by 1 cycle.
  - `req` deassertion during LOAD is ignored; the grant runs to completion.
  - `last_src` is updated to the winner at grant.
  - After the count reaches NFFT-1, the state moves to PROC.
- **PROC**
  - A timeout counter counts up from 0.
  - On `fft_complete`=1, the state moves to DRAIN.
  - When the counter reaches TIMEOUT, `err_timeout` is set, the frame is abandoned, and the state returns to IDLE.
- **DRAIN**
  - `fft_ready_recive` = `out_ready` (combinational, DRAIN only; 0 elsewhere).
  - `out_valid` = `fft_complete` (DRAIN only).
  - `out_i/q` pass through from the core.
  - `out_src` holds the frame source.
  - The output counter increments on each transfer. `out_last` = `out_valid` and counter = NFFT-1.
  - After the last transfer, the state returns to IDLE.
- **Single frame in flight:** no new grant is issued before DRAIN ends.

## Timing
- **Reset values (asynchronous):** every output is 0, except the pass-through data, which reads 0 outside DRAIN. State = IDLE, all counters = 0, `last_src` = 1.
- **Grant latency:** `req` and `fft_wait_data` sampled high at edge N → `gnt` high from edge N+1 through edge N+NFFT.
- **Core input latency:** `fft_valid` high from edge N+2 for NFFT cycles. Sample k presented at gnt cycle k reaches the core 1 cycle later.
- **Back-to-back frames:** the earliest next grant is the cycle after the DRAIN exit edge, provided `fft_wait_data`=1.
- **Backpressure:** `out_ready`=0 stalls the core via `fft_ready_recive`. No samples are dropped or duplicated, and the counter holds.
- **`fft_complete` drops mid-DRAIN:** `out_valid`=0 and the counter holds.
- **Reset mid-frame:** any grant or `fft_valid` drops immediately. The core frame is abandoned; the next frame is issued only after `fft_wait_data`=1.
- **`busy`:** registered, equal to (state ≠ IDLE).

## Test plan
- **Single source, no stall:** `req0`=1 only, ramp data 0..255 → `gnt0` high exactly 256 cycles. `fft_valid` is delayed by 1 with identical data. 256 outputs follow, `out_src`=0, and `out_last` fires only on the 256th transfer.
- **Tie arbitration:** `req0`=`req1`=1 continuously → grants alternate 0,1,0,1 over 4 frames. The first grant is `gnt0`. `gnt0` and `gnt1` are never high together.
- **Backpressure:** toggle `out_ready` 1,0,0,1 repeating during DRAIN → `fft_ready_recive` mirrors it and exactly 256 transfers complete. Output values match the unstalled run.
- **Core not ready:** `fft_wait_data`=0 with `req1`=1 for 100 cycles → no grant and `busy`=0. Grant follows 1 cycle after `fft_wait_data` rises.
- **Timeout:** TIMEOUT=50, `fft_complete` held 0 → `err_timeout` sets exactly 50 cycles after PROC entry, the state returns to IDLE, and the flag stays set across later frames.
- **Reset mid-LOAD:** assert `reset`=0 at load count 100 → `gnt0`, `fft_valid`, and `busy` go 0 asynchronously. After release, `req0` obtains a fresh full 256-cycle grant.
